fork_join_ctrl: RTL and testbench
=================================

# fork_join_ctrl

Synthesizable join-side controller for concurrent worker threads. A parent issues a fork request with a thread mask and a join mode. The block pulses start to the selected workers, tracks their done pulses, and returns a join handshake when the mode's completion condition holds. Modes follow SystemVerilog semantics: join (all), join_any (first) and join_none (immediate). It sits between a sequencing master and a bank of independent worker engines.

## Interface
- N_THREADS, 4, number of worker threads (1..32)
- TIMEOUT_W, 16, width of wait-timeout counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- fork_valid  in  1  fork request valid
- fork_ready  out  1  fork request accepted when high with fork_valid
- fork_mask  in  N_THREADS  threads to launch
- fork_mode  in  2  00 ALL, 01 ANY, 10 NONE, 11 reserved (treated as ALL)
- start  out  N_THREADS  one-cycle launch pulse per thread
- done  in  N_THREADS  one-cycle completion pulse per thread
- join_valid  out  1  join condition met; held until join_ready
- join_ready  in  1  parent consumes join
- join_mask  out  N_THREADS  threads of the current fork that completed, valid with join_valid
- pending  out  N_THREADS  threads launched and not yet done (across all forks)
- busy  out  1  state != IDLE
- timeout_max  in  TIMEOUT_W  WAIT cycle limit; 0 disables
- timeout_err  out  1  join produced by timeout, valid with join_valid

## Operation
- States: IDLE, LAUNCH, WAIT, JOIN.
- IDLE:
  - fork_ready = ((fork_mask & pending) == 0). The combinational dependence on fork_mask is intentional; it blocks relaunching a running thread.
  - On accept, latch mode and mask, clear join_mask and the timer, then go to LAUNCH.
  - An accepted mask of 0 goes directly to JOIN with join_mask 0.
- LAUNCH (1 cycle): start = latched mask. pending |= mask. Next state is WAIT, or JOIN if the mode is NONE.
- WAIT: each cycle, cur_done = done & pending & fork_set, and join_mask |= cur_done. Exit to JOIN when either:
  - ALL: join_mask == fork_set (including the current cycle's done)
  - ANY: cur_done != 0
- pending update, every state: pending <= (pending & ~done) | launch_bits. Done pulses for non-pending threads are ignored. Threads left running by ANY/NONE keep clearing pending in later forks and in IDLE.
- Timeout: the timer increments each WAIT cycle. When timer == timeout_max - 1 (timeout_max != 0) and the condition is still unmet, go to JOIN with timeout_err = 1. pending is not cleared.
- JOIN: join_valid = 1, and join_mask/timeout_err are held stable. On join_ready, go to IDLE. Later dones do not alter the held join_mask.
- Simultaneous events:
  - A done in the same cycle as the ALL/ANY condition is included in join_mask.
  - A done in the same cycle as a timeout expiry counts as success, with timeout_err = 0.
- Reset (any state, including mid-WAIT):
  - state IDLE
  - start, pending, join_mask, timer, join_valid, timeout_err, busy = 0
  - fork_ready = 1 for any mask
  - dones arriving after reset are ignored

## Timing
- Fork accepted in cycle T: start pulses in T+1, pending is set at end of T+1, WAIT begins at T+2.
- NONE: join_valid at T+2.
- ALL/ANY: last qualifying done sampled in cycle D gives join_valid in D+1.
- Minimum fork-to-fork with join_ready tied high: 3 cycles for NONE.
- Done for a thread is sampled from T+2 onward. A done in T+1 (the same cycle as start) is ignored for the new fork.
- All outputs are registered except fork_ready.

## Structure
- Package fork_join_pkg holds:
  - typedef enum logic [1:0] join_mode_e {JM_ALL, JM_ANY, JM_NONE, JM_RSVD}
  - typedef enum logic [1:0] fj_state_e {S_IDLE, S_LAUNCH, S_WAIT, S_JOIN}
- One sub-module, fj_timeout_timer: clear, enable, limit, expire; TIMEOUT_W wide.
- The rest (state register, mask bookkeeping) lives in fork_join_ctrl.

## Test plan
- ALL:
  - Stimulus: fork mask 4'b0111; done[2] at +2, done[0] at +5, done[1] at +8 cycles after start.
  - Response: join_valid 1 cycle after done[1], join_mask 0111, timeout_err 0.
- ANY:
  - Stimulus: mask 4'b1010; done[3] at +3, done[1] at +6.
  - Response: join_valid 1 cycle after done[3], join_mask 1000, pending 0010 until done[1], then 0000.
- NONE then overlap:
  - Stimulus: mask 4'b0011 NONE; join_valid 2 cycles after accept. Next fork mask 4'b0001 while thread 0 is pending.
  - Response: fork_ready 0. Fork mask 4'b1100 is accepted instead.
- Timeout:
  - Stimulus: timeout_max 10, ALL mask 4'b0001, no done.
  - Response: join_valid with timeout_err 1 after 10 WAIT cycles, pending 0001. A later done[0] clears pending.
- Backpressure and zero mask:
  - Stimulus: hold join_ready 0 for 5 cycles while an extra done arrives; separately, fork mask 0.
  - Response: join_mask unchanged during backpressure. Mask-0 fork gives join_valid at T+1 with join_mask 0.
- Reset mid-WAIT:
  - Stimulus: assert rst with 3 threads pending, then send dones.
  - Response: all outputs 0, fork_ready 1, pending stays 0.

Source files
------------

// File: rtl/fork_join_pkg.sv
// Shared join modes and controller states for the fork/join controller.
// Pure typedefs: no logic, no latency, no flow control.
package fork_join_pkg;

  typedef enum logic [1:0] {JM_ALL, JM_ANY, JM_NONE, JM_RSVD} join_mode_e;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_JOIN} fj_state_e;

endpackage

// File: rtl/fj_timeout_timer.sv
// WAIT-phase cycle counter; expire is combinational on the cycle count reaches limit-1.
// Zero latency on expire; no backpressure, limit of 0 never expires.
module fj_timeout_timer #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expire
);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign expire = enable && (limit != '0) && (count == limit - TIMEOUT_W'(1));

endmodule

// File: rtl/fork_join_ctrl.sv
// Launches worker threads on a fork and returns a join once the all/any/none condition holds.
// Start one cycle after accept, join one cycle after the deciding done; join held until join_ready.
module fork_join_ctrl
  import fork_join_pkg::*;
#(
  parameter int N_THREADS = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fork_valid,
  output logic                 fork_ready,
  input  logic [N_THREADS-1:0] fork_mask,
  input  logic [1:0]           fork_mode,
  output logic [N_THREADS-1:0] start,
  input  logic [N_THREADS-1:0] done,
  output logic                 join_valid,
  input  logic                 join_ready,
  output logic [N_THREADS-1:0] join_mask,
  output logic [N_THREADS-1:0] pending,
  output logic                 busy,
  input  logic [TIMEOUT_W-1:0] timeout_max,
  output logic                 timeout_err
);

  fj_state_e              state;
  join_mode_e             mode;
  logic [N_THREADS-1:0]   fork_set;
  logic [N_THREADS-1:0]   cur_done;
  logic [N_THREADS-1:0]   jm_next;
  logic [N_THREADS-1:0]   launch_bits;
  logic                   accept;
  logic                   cond_met;
  logic                   expire;

  // A thread still running from an earlier fork may not be relaunched.
  assign fork_ready  = (state == S_IDLE) && ((fork_mask & pending) == '0);
  assign accept      = fork_valid && fork_ready;

  assign cur_done    = done & pending & fork_set;
  assign jm_next     = join_mask | cur_done;
  assign cond_met    = (mode == JM_ANY) ? (cur_done != '0) : (jm_next == fork_set);
  assign launch_bits = (state == S_LAUNCH) ? fork_set : '0;

  fj_timeout_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (state == S_WAIT),
    .limit  (timeout_max),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mode        <= JM_ALL;
      fork_set    <= '0;
      start       <= '0;
      pending     <= '0;
      join_mask   <= '0;
      join_valid  <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pending <= (pending & ~done) | launch_bits;
      start   <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mode        <= join_mode_e'(fork_mode);
            fork_set    <= fork_mask;
            join_mask   <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            if (fork_mask == '0) begin
              state      <= S_JOIN;
              join_valid <= 1'b1;
            end else begin
              state <= S_LAUNCH;
              start <= fork_mask;
            end
          end
        end
        S_LAUNCH: begin
          if (mode == JM_NONE) begin
            state      <= S_JOIN;
            join_valid <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          join_mask <= jm_next;
          // A completing done outranks an expiring timer in the same cycle.
          if (cond_met) begin
            state      <= S_JOIN;
            join_valid <= 1'b1;
          end else if (expire) begin
            state       <= S_JOIN;
            join_valid  <= 1'b1;
            timeout_err <= 1'b1;
          end
        end
        S_JOIN: begin
          if (join_ready) begin
            state       <= S_IDLE;
            join_valid  <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Directed bench: each fork pushes its expected join onto a queue, an independent
// monitor pops and compares on every join handshake; side checks run inline.
module tb_fork_join_ctrl;
  import fork_join_pkg::*;

  localparam int N  = 4;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fork_valid;
  logic          fork_ready;
  logic [N-1:0]  fork_mask;
  logic [1:0]    fork_mode;
  logic [N-1:0]  start;
  logic [N-1:0]  done;
  logic          join_valid;
  logic          join_ready;
  logic [N-1:0]  join_mask;
  logic [N-1:0]  pending;
  logic          busy;
  logic [TW-1:0] timeout_max;
  logic          timeout_err;

  fork_join_ctrl #(.N_THREADS(N), .TIMEOUT_W(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .fork_valid  (fork_valid),
    .fork_ready  (fork_ready),
    .fork_mask   (fork_mask),
    .fork_mode   (fork_mode),
    .start       (start),
    .done        (done),
    .join_valid  (join_valid),
    .join_ready  (join_ready),
    .join_mask   (join_mask),
    .pending     (pending),
    .busy        (busy),
    .timeout_max (timeout_max),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [N-1:0] mask;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endtask

  // Monitor: records when join_valid first rises, scores each handshake.
  bit seen = 1'b0;
  int rise = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (join_valid && !seen) begin
        seen = 1'b1;
        rise = cyc;
      end
      if (join_valid && join_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_join", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("join_mask", 32'(join_mask), 32'(e.mask));
          chk("timeout_err", 32'(timeout_err), 32'(e.err));
          chk("join_latency", 32'(rise), 32'(e.cyc));
        end
        seen = 1'b0;
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    goto(c);
    @(negedge clk);
  endtask

  task automatic pulse(input logic [N-1:0] bits, input int c);
    goto(c);
    done = bits;
    @(posedge clk);
    #1;
    done = '0;
  endtask

  // Issue a fork; rel >= 0 queues the expected join at accept cycle + rel.
  task automatic do_fork(input logic [N-1:0] m, input logic [1:0] md, input logic [N-1:0] em,
                         input logic ee, input int rel, output int t);
    bit ok;
    ok = 1'b0;
    t  = -1;
    @(posedge clk);
    #1;
    fork_valid = 1'b1;
    fork_mask  = m;
    fork_mode  = md;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fork_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      chk("fork_accept_timeout", 32'd0, 32'd1);
      fork_valid = 1'b0;
    end else begin
      t = cyc;
      if (rel >= 0) exp_q.push_back('{em, ee, t + rel});
      @(posedge clk);
      #1;
      fork_valid = 1'b0;
      @(negedge clk);
      chk("start", 32'(start), 32'(m));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    fork_valid  = 1'b0;
    fork_mask   = '0;
    fork_mode   = 2'd0;
    done        = '0;
    join_ready  = 1'b1;
    timeout_max = '0;
    rst         = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    fork_mask = 4'b1111;
    @(negedge clk);
    chk("rst_join_valid", 32'(join_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_fork_ready", 32'(fork_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ALL: dones at start+2, +5, +8; join one cycle after the last
    do_fork(4'b0111, 2'd0, 4'b0111, 1'b0, 10, t);
    chk("all_busy", 32'(busy), 32'd1);
    pulse(4'b0100, t + 3);
    pulse(4'b0001, t + 6);
    pulse(4'b0010, t + 9);
    drain();

    // ANY: first done wins, second thread keeps running
    do_fork(4'b1010, 2'd1, 4'b1000, 1'b0, 5, t);
    pulse(4'b1000, t + 4);
    at_neg(t + 5);
    chk("any_pending_a", 32'(pending), 32'b0010);
    at_neg(t + 6);
    chk("any_pending_b", 32'(pending), 32'b0010);
    pulse(4'b0010, t + 7);
    at_neg(t + 8);
    chk("any_pending_c", 32'(pending), 32'b0000);
    drain();

    // NONE, then overlap rejection and a disjoint fork
    do_fork(4'b0011, 2'd2, 4'b0000, 1'b0, 2, t);
    at_neg(t + 2);
    chk("none_pending", 32'(pending), 32'b0011);
    goto(t + 3);
    fork_valid = 1'b1;
    fork_mask  = 4'b0001;
    fork_mode  = 2'd0;
    @(negedge clk);
    chk("overlap_fork_ready", 32'(fork_ready), 32'd0);
    @(posedge clk);
    #1;
    fork_valid = 1'b0;
    do_fork(4'b1100, 2'd0, 4'b1100, 1'b0, 6, t);
    pulse(4'b0101, t + 3);
    pulse(4'b1010, t + 5);
    drain();
    @(negedge clk);
    chk("overlap_pending", 32'(pending), 32'b0000);

    // Timeout, with a done in the launch cycle that must be ignored
    timeout_max = 16'd10;
    do_fork(4'b0001, 2'd0, 4'b0000, 1'b1, 12, t);
    done = 4'b0001;
    @(posedge clk);
    #1;
    done = '0;
    at_neg(t + 11);
    chk("to_not_early", 32'(join_valid), 32'd0);
    at_neg(t + 12);
    chk("to_pending_held", 32'(pending), 32'b0001);
    pulse(4'b0001, t + 14);
    at_neg(t + 15);
    chk("to_pending_clear", 32'(pending), 32'b0000);
    timeout_max = '0;
    drain();

    // Backpressure: join held 5 cycles while another thread finishes
    join_ready = 1'b0;
    do_fork(4'b0011, 2'd1, 4'b0001, 1'b0, 3, t);
    pulse(4'b0001, t + 2);
    for (int k = 3; k <= 7; k++) begin
      goto(t + k);
      done = (k == 5) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      chk("bp_join_mask", 32'(join_mask), 32'b0001);
      chk("bp_join_valid", 32'(join_valid), 32'd1);
    end
    goto(t + 8);
    done       = '0;
    join_ready = 1'b1;
    @(negedge clk);
    chk("bp_pending", 32'(pending), 32'b0000);
    drain();

    // Zero mask: immediate join
    do_fork(4'b0000, 2'd0, 4'b0000, 1'b0, 1, t);
    drain();

    // Reset mid-WAIT with three threads pending
    do_fork(4'b0111, 2'd0, 4'b0000, 1'b0, -1, t);
    goto(t + 3);
    chk("mid_pending", 32'(pending), 32'b0111);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    fork_mask  = 4'b1111;
    @(negedge clk);
    chk("mr_join_valid", 32'(join_valid), 32'd0);
    chk("mr_start", 32'(start), 32'd0);
    chk("mr_pending", 32'(pending), 32'd0);
    chk("mr_join_mask", 32'(join_mask), 32'd0);
    chk("mr_timeout_err", 32'(timeout_err), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_fork_ready", 32'(fork_ready), 32'd1);
    goto(t + 5);
    done = 4'b0111;
    @(posedge clk);
    #1;
    done = '0;
    @(negedge clk);
    chk("mr_pending_after_done", 32'(pending), 32'd0);
    repeat (5) @(negedge clk);
    chk("mr_no_join", 32'(join_valid), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
